// File: rtl/lap_recall_ctrl_pkg.sv
// Shared definitions for the lap recall sequencer.
//   state_t   : sequencer states (live time vs. recalled lap)
//   BCD_W     : width of one BCD digit
//   TIME_W    : packed time width {sec_tens, sec_ones, hund_tens, hund_ones}
//   pack_time : packs four BCD digits, MSB first
package lap_recall_ctrl_pkg;

    localparam int unsigned BCD_W  = 4;
    localparam int unsigned TIME_W = 16;

    typedef enum logic {
        ST_LIVE   = 1'b0,
        ST_RECALL = 1'b1
    } state_t;

    function automatic logic [TIME_W-1:0] pack_time(
        input logic [BCD_W-1:0] sec_tens,
        input logic [BCD_W-1:0] sec_ones,
        input logic [BCD_W-1:0] hund_tens,
        input logic [BCD_W-1:0] hund_ones
    );
        return {sec_tens, sec_ones, hund_tens, hund_ones};
    endfunction

endpackage

// File: rtl/lap_recall_ctrl_regfile.sv
// Lap snapshot store: DEPTH x W, one synchronous write port and one
// combinational read port. Storage has no reset; entries beyond the live
// count are never read.
//   i_clk   : system clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : snapshot to store
//   i_raddr : read index
//   o_rdata : entry at i_raddr (combinational)
module lap_regfile #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned W     = 16
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [W-1:0]     o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lap_recall_ctrl.sv
// Lap recall sequencer. Captures live stopwatch time into a small store on
// lap requests, steps the display through stored laps on recall requests,
// and returns the display to live time on wrap, timeout or clear.
//   clk, rst                : clock, asynchronous active-high reset
//   running                 : counter enabled (gates captures)
//   lap_pulse               : capture request
//   recall_pulse            : enter recall / step to next lap
//   clear_pulse             : drop all laps, return to live
//   live_*                  : current BCD time digits
//   disp_*                  : registered BCD digits for the decoders
//   recall_active           : high while showing a stored lap
//   lap_index               : lap being shown (0 in live)
//   lap_count               : number of stored laps
//   overflow                : sticky, a capture was dropped while full
import lap_recall_ctrl_pkg::*;

module lap_recall_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned N_TIMEOUT = 150_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             running,
    input  logic             lap_pulse,
    input  logic             recall_pulse,
    input  logic             clear_pulse,
    input  logic [3:0]       live_sec_tens,
    input  logic [3:0]       live_sec_ones,
    input  logic [3:0]       live_hund_tens,
    input  logic [3:0]       live_hund_ones,
    output logic [3:0]       disp_sec_tens,
    output logic [3:0]       disp_sec_ones,
    output logic [3:0]       disp_hund_tens,
    output logic [3:0]       disp_hund_ones,
    output logic             recall_active,
    output logic [IDX_W-1:0] lap_index,
    output logic [IDX_W:0]   lap_count,
    output logic             overflow
);

    localparam int unsigned     TO_W    = (N_TIMEOUT > 1) ? $clog2(N_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(N_TIMEOUT - 1);
    localparam logic [IDX_W:0]  DEPTH_C = (IDX_W+1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_lap_index;
    logic [IDX_W-1:0]  w_index_nxt;
    logic [IDX_W:0]    r_lap_count;
    logic [IDX_W:0]    w_count_nxt;
    logic              r_overflow;
    logic              w_overflow_nxt;
    logic [TO_W-1:0]   r_timeout;
    logic [TO_W-1:0]   w_timeout_nxt;
    logic [TIME_W-1:0] r_disp;
    logic [TIME_W-1:0] w_disp_nxt;
    logic [TIME_W-1:0] w_live;
    logic [TIME_W-1:0] w_rdata;
    logic              w_full;
    logic              w_capture;
    logic              w_last;

    assign w_live    = pack_time(live_sec_tens, live_sec_ones, live_hund_tens, live_hund_ones);
    assign w_full    = (r_lap_count == DEPTH_C);
    assign w_capture = lap_pulse && running && !w_full && !clear_pulse;
    assign w_last    = ({1'b0, r_lap_index} == (r_lap_count - (IDX_W+1)'(1)));

    // Read address is the next-state index; it is always below the pre-edge
    // count, which is the write address, so a same-cycle capture never aliases.
    lap_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .W     (TIME_W)
    ) u_regfile (
        .i_clk   (clk),
        .i_we    (w_capture),
        .i_waddr (r_lap_count[IDX_W-1:0]),
        .i_wdata (w_live),
        .i_raddr (w_index_nxt),
        .o_rdata (w_rdata)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LIVE;
            r_lap_index <= '0;
            r_lap_count <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= '0;
            r_disp      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lap_index <= w_index_nxt;
            r_lap_count <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_timeout   <= w_timeout_nxt;
            r_disp      <= w_disp_nxt;
        end
    end

    // Next-state logic; clear overrides every other request
    always_comb begin
        w_state_nxt    = r_state;
        w_index_nxt    = r_lap_index;
        w_count_nxt    = r_lap_count;
        w_overflow_nxt = r_overflow;
        w_timeout_nxt  = r_timeout;

        if (clear_pulse) begin
            w_state_nxt    = ST_LIVE;
            w_index_nxt    = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            if (lap_pulse && running) begin
                if (w_full) begin
                    w_overflow_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_lap_count + (IDX_W+1)'(1);
                end
            end

            // Recall decisions use the pre-edge count, so a capture in the
            // same cycle cannot make an empty store enterable.
            unique case (r_state)
                ST_LIVE: begin
                    if (recall_pulse && (r_lap_count != '0)) begin
                        w_state_nxt   = ST_RECALL;
                        w_index_nxt   = '0;
                        w_timeout_nxt = TO_LOAD;
                    end
                end
                ST_RECALL: begin
                    if (recall_pulse) begin
                        if (w_last) begin
                            w_state_nxt = ST_LIVE;
                            w_index_nxt = '0;
                        end else begin
                            w_index_nxt   = r_lap_index + IDX_W'(1);
                            w_timeout_nxt = TO_LOAD;
                        end
                    end else if (r_timeout == '0) begin
                        w_state_nxt = ST_LIVE;
                        w_index_nxt = '0;
                    end else begin
                        w_timeout_nxt = r_timeout - TO_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_LIVE;
                    w_index_nxt = '0;
                end
            endcase
        end
    end

    // Outputs: display source follows the next state so it lands with it
    always_comb begin
        w_disp_nxt    = (w_state_nxt == ST_RECALL) ? w_rdata : w_live;
        recall_active = (r_state == ST_RECALL);
    end

    assign lap_index      = r_lap_index;
    assign lap_count      = r_lap_count;
    assign overflow       = r_overflow;
    assign disp_sec_tens  = r_disp[15:12];
    assign disp_sec_ones  = r_disp[11:8];
    assign disp_hund_tens = r_disp[7:4];
    assign disp_hund_ones = r_disp[3:0];

endmodule

// File: tb/tb_lap_recall_ctrl.sv
module tb_lap_recall_ctrl;

    localparam int M_DEPTH = 4;
    localparam int M_NTO   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       running, lap_pulse, recall_pulse, clear_pulse;
    logic [3:0] live_sec_tens, live_sec_ones, live_hund_tens, live_hund_ones;
    logic [3:0] disp_sec_tens, disp_sec_ones, disp_hund_tens, disp_hund_ones;
    logic       recall_active;
    logic [1:0] lap_index;
    logic [2:0] lap_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    // Reference model: list of stored laps, recall position, idle edges.
    logic [15:0] m_mem [M_DEPTH];
    int          m_count;
    bit          m_over;
    bit          m_rec;
    int          m_idx;
    int          m_idle;
    logic [15:0] m_disp;

    lap_recall_ctrl #(
        .DEPTH     (M_DEPTH),
        .IDX_W     (2),
        .N_TIMEOUT (M_NTO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .running        (running),
        .lap_pulse      (lap_pulse),
        .recall_pulse   (recall_pulse),
        .clear_pulse    (clear_pulse),
        .live_sec_tens  (live_sec_tens),
        .live_sec_ones  (live_sec_ones),
        .live_hund_tens (live_hund_tens),
        .live_hund_ones (live_hund_ones),
        .disp_sec_tens  (disp_sec_tens),
        .disp_sec_ones  (disp_sec_ones),
        .disp_hund_tens (disp_hund_tens),
        .disp_hund_ones (disp_hund_ones),
        .recall_active  (recall_active),
        .lap_index      (lap_index),
        .lap_count      (lap_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] disp_word();
        return {disp_sec_tens, disp_sec_ones, disp_hund_tens, disp_hund_ones};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_over = 0; m_rec = 0; m_idx = 0; m_idle = 0; m_disp = '0;
    endtask

    task automatic model_edge(input bit lp, input bit rp, input bit cp, input bit run,
                              input logic [15:0] live);
        int old_count;
        old_count = m_count;
        if (cp) begin
            m_count = 0; m_over = 0; m_rec = 0; m_idx = 0;
        end else begin
            if (lp && run) begin
                if (m_count < M_DEPTH) begin
                    m_mem[m_count] = live;
                    m_count++;
                end else begin
                    m_over = 1;
                end
            end
            if (!m_rec) begin
                if (rp && old_count > 0) begin
                    m_rec = 1; m_idx = 0; m_idle = 0;
                end
            end else if (rp) begin
                if (m_idx == old_count - 1) begin
                    m_rec = 0; m_idx = 0;
                end else begin
                    m_idx++; m_idle = 0;
                end
            end else begin
                m_idle++;
                if (m_idle >= M_NTO) begin
                    m_rec = 0; m_idx = 0;
                end
            end
        end
        m_disp = m_rec ? m_mem[m_idx] : live;
    endtask

    task automatic check_all();
        chk("disp", 32'(disp_word()), 32'(m_disp));
        chk("recall_active", 32'(recall_active), 32'(m_rec));
        chk("lap_index", 32'(lap_index), 32'(m_idx));
        chk("lap_count", 32'(lap_count), 32'(m_count));
        chk("overflow", 32'(overflow), 32'(m_over));
    endtask

    task automatic step(input bit lp, input bit rp, input bit cp, input bit run,
                        input logic [15:0] live);
        lap_pulse    = lp;
        recall_pulse = rp;
        clear_pulse  = cp;
        running      = run;
        {live_sec_tens, live_sec_ones, live_hund_tens, live_hund_ones} = live;
        @(posedge clk);
        model_edge(lp, rp, cp, run, live);
        #1;
        check_all();
    endtask

    initial begin
        int fall;
        logic [15:0] rl;

        rst = 1'b1;
        running = 0; lap_pulse = 0; recall_pulse = 0; clear_pulse = 0;
        {live_sec_tens, live_sec_ones, live_hund_tens, live_hund_ones} = 16'h0000;
        for (int i = 0; i < M_DEPTH; i++) m_mem[i] = '0;
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;

        // Live display after one edge
        step(0, 0, 0, 0, 16'h1234);
        chk("live_1234", 32'(disp_word()), 32'h1234);

        // Three laps then recall through them and back to live
        step(1, 0, 0, 1, 16'h0110);
        step(1, 0, 0, 1, 16'h0220);
        step(1, 0, 0, 1, 16'h0330);
        chk("count3", 32'(lap_count), 32'd3);
        step(0, 1, 0, 1, 16'h0400);
        chk("rc0", 32'(disp_word()), 32'h0110);
        step(0, 1, 0, 1, 16'h0410);
        chk("rc1", 32'(disp_word()), 32'h0220);
        step(0, 1, 0, 1, 16'h0420);
        chk("rc2", 32'(disp_word()), 32'h0330);
        chk("rc2_idx", 32'(lap_index), 32'd2);
        step(0, 1, 0, 1, 16'h0430);
        chk("rc_wrap", 32'(recall_active), 32'd0);
        chk("rc_wrap_live", 32'(disp_word()), 32'h0430);

        // Fill and overflow, then clear
        step(1, 0, 0, 1, 16'h0440);
        step(1, 0, 0, 1, 16'h0550);
        chk("full_count", 32'(lap_count), 32'd4);
        chk("full_ovf", 32'(overflow), 32'd1);
        step(0, 0, 1, 1, 16'h0560);
        chk("clr_count", 32'(lap_count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Recall with empty store, coincident with first capture
        step(1, 1, 0, 1, 16'h0707);
        chk("empty_rc", 32'(recall_active), 32'd0);
        chk("empty_rc_cnt", 32'(lap_count), 32'd1);

        // Timeout back to live
        step(0, 1, 0, 1, 16'h0800);
        chk("to_enter", 32'(disp_word()), 32'h0707);
        fall = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, 1, 16'(16'h0810 + i));
            if (!recall_active && fall == 0) fall = i;
        end
        chk("timeout_edges", 32'(fall), 32'd10);

        // Clear with coincident lap while recalling at index 1
        step(1, 0, 0, 1, 16'h0909);
        step(0, 1, 0, 1, 16'h0910);
        step(0, 1, 0, 1, 16'h0911);
        chk("idx1", 32'(lap_index), 32'd1);
        step(1, 0, 1, 1, 16'h0912);
        chk("clr_lap_cnt", 32'(lap_count), 32'd0);
        chk("clr_lap_rc", 32'(recall_active), 32'd0);

        // Asynchronous reset between edges while recalling
        step(1, 0, 0, 1, 16'h1111);
        step(0, 1, 0, 1, 16'h1112);
        chk("pre_rst_rc", 32'(recall_active), 32'd1);
        lap_pulse = 0; recall_pulse = 0; clear_pulse = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rl = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0)),
                  4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
            step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 40) == 0,
                 ($urandom % 8) != 0, rl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
